// File: rtl/dealer_pkg.sv
// Shared types and constants for the memory-card dealer.
package dealer_pkg;

   localparam int unsigned CARD_W    = 3;
   localparam int unsigned SLOT_W    = 4;
   localparam int unsigned NUM_SLOTS = 16;
   localparam int unsigned SCORE_W   = 4;

   typedef enum logic [2:0] {
      WAIT_FIRST,
      SHOW_FIRST,
      WAIT_SECOND,
      SHOW_SECOND,
      JUDGE,
      DONE
   } state_t;

   // Slot i and slot i+NUM_SLOTS/2 always carry the same value.
   function automatic logic [CARD_W-1:0] slot_value(input int unsigned idx, input int unsigned seed);
      return CARD_W'(((idx % (NUM_SLOTS / 2)) + seed) % (NUM_SLOTS / 2));
   endfunction

endpackage

// File: rtl/dealer_if.sv
// Pick request / reveal / score bundle between a player driver and card_dealer.
interface dealer_if;
   import dealer_pkg::*;

   logic                pick;
   logic [SLOT_W-1:0]   sel;
   logic                ready;
   logic [CARD_W-1:0]   card;
   logic                card_valid;
   logic                player;
   logic                match;
   logic                mismatch;
   logic                error;
   logic [SCORE_W-1:0]  score0;
   logic [SCORE_W-1:0]  score1;
   logic                done;

   modport master (
      output pick, sel,
      input  ready, card, card_valid, player, match, mismatch, error, score0, score1, done
   );

   modport slave (
      input  pick, sel,
      output ready, card, card_valid, player, match, mismatch, error, score0, score1, done
   );

endinterface

// File: rtl/dealer_board.sv
// Card values and matched flags for all slots; one combinational read port, one two-slot set port.
module dealer_board
   import dealer_pkg::*;
#(
   parameter int unsigned SEED = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SLOT_W-1:0] i_rd_idx,
   output logic [CARD_W-1:0] o_rd_val,
   output logic              o_rd_matched,
   input  logic              i_set_en,
   input  logic [SLOT_W-1:0] i_set_a,
   input  logic [SLOT_W-1:0] i_set_b
);

   logic [CARD_W-1:0]    r_val [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_matched;

   // Values are only loaded by reset; they stay fixed for the whole game.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            r_val[i] <= slot_value(i, SEED);
         end
         r_matched <= '0;
      end else if (i_set_en) begin
         r_matched[i_set_a] <= 1'b1;
         r_matched[i_set_b] <= 1'b1;
      end
   end

   assign o_rd_val     = r_val[i_rd_idx];
   assign o_rd_matched = r_matched[i_rd_idx];

endmodule

// File: rtl/card_dealer.sv
// Two-player memory game controller: reveal two slots per turn, judge, score, detect end of game.
module card_dealer
   import dealer_pkg::*;
#(
   parameter int unsigned SEED      = 3,
   parameter int unsigned NUM_PAIRS = 8
) (
   input  logic    clk,
   input  logic    rst,
   dealer_if.slave bus
);

   localparam logic [SCORE_W:0] PAIRS_GOAL = (SCORE_W + 1)'(NUM_PAIRS);

   state_t              r_state;
   logic                r_ready;
   logic                r_card_valid;
   logic [CARD_W-1:0]   r_card;
   logic                r_match;
   logic                r_mismatch;
   logic                r_error;
   logic                r_player;
   logic                r_done;
   logic [SCORE_W-1:0]  r_score0;
   logic [SCORE_W-1:0]  r_score1;
   logic [SLOT_W-1:0]   r_first_slot;
   logic [SLOT_W-1:0]   r_second_slot;
   logic [CARD_W-1:0]   r_first_val;
   logic [CARD_W-1:0]   r_second_val;

   logic [CARD_W-1:0]   w_sel_val;
   logic                w_sel_matched;
   logic                w_accept;
   logic                w_legal;
   logic                w_pair_equal;
   logic                w_set_en;
   logic [SCORE_W:0]    w_pairs;

   dealer_board #(.SEED(SEED)) u_board (
      .clk          (clk),
      .rst          (rst),
      .i_rd_idx     (bus.sel),
      .o_rd_val     (w_sel_val),
      .o_rd_matched (w_sel_matched),
      .i_set_en     (w_set_en),
      .i_set_a      (r_first_slot),
      .i_set_b      (r_second_slot)
   );

   // r_ready is only ever high in the two WAIT states, so it doubles as the accept gate.
   assign w_accept     = bus.pick & r_ready;
   assign w_legal      = !w_sel_matched && ((r_state == WAIT_FIRST) || (bus.sel != r_first_slot));
   assign w_pair_equal = (r_first_val == r_second_val);
   assign w_set_en     = (r_state == SHOW_SECOND) && w_pair_equal;
   assign w_pairs      = {1'b0, r_score0} + {1'b0, r_score1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= WAIT_FIRST;
         r_ready       <= 1'b0;
         r_card_valid  <= 1'b0;
         r_card        <= '0;
         r_match       <= 1'b0;
         r_mismatch    <= 1'b0;
         r_error       <= 1'b0;
         r_player      <= 1'b0;
         r_done        <= 1'b0;
         r_score0      <= '0;
         r_score1      <= '0;
         r_first_slot  <= '0;
         r_second_slot <= '0;
         r_first_val   <= '0;
         r_second_val  <= '0;
      end else begin
         r_card_valid <= 1'b0;
         r_card       <= '0;
         r_match      <= 1'b0;
         r_mismatch   <= 1'b0;
         r_error      <= 1'b0;
         case (r_state)
            WAIT_FIRST, WAIT_SECOND: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  if (w_legal) begin
                     r_card       <= w_sel_val;
                     r_card_valid <= 1'b1;
                     r_ready      <= 1'b0;
                     if (r_state == WAIT_FIRST) begin
                        r_first_slot <= bus.sel;
                        r_first_val  <= w_sel_val;
                        r_state      <= SHOW_FIRST;
                     end else begin
                        r_second_slot <= bus.sel;
                        r_second_val  <= w_sel_val;
                        r_state       <= SHOW_SECOND;
                     end
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            SHOW_FIRST: begin
               r_ready <= 1'b1;
               r_state <= WAIT_SECOND;
            end
            // Verdict, flags, score and player all settle on entry to JUDGE.
            SHOW_SECOND: begin
               r_state <= JUDGE;
               if (w_pair_equal) begin
                  r_match <= 1'b1;
                  if (w_pairs < PAIRS_GOAL) begin
                     if (r_player) r_score1 <= r_score1 + 1'b1;
                     else          r_score0 <= r_score0 + 1'b1;
                  end
               end else begin
                  r_mismatch <= 1'b1;
                  r_player   <= ~r_player;
               end
            end
            JUDGE: begin
               if (w_pairs == PAIRS_GOAL) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_ready <= 1'b0;
               end else begin
                  r_state <= WAIT_FIRST;
                  r_ready <= 1'b1;
               end
            end
            DONE: begin
               r_ready <= 1'b0;
            end
            default: begin
               r_state <= WAIT_FIRST;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = r_ready;
   assign bus.card       = r_card;
   assign bus.card_valid = r_card_valid;
   assign bus.player     = r_player;
   assign bus.match      = r_match;
   assign bus.mismatch   = r_mismatch;
   assign bus.error      = r_error;
   assign bus.score0     = r_score0;
   assign bus.score1     = r_score1;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: fixed vectors, corner sequences and a random game vs a turn-level model.
module tb_card_dealer;
   import dealer_pkg::*;

   localparam int unsigned SEED      = 3;
   localparam int unsigned NUM_PAIRS = 8;

   logic clk = 1'b0;
   logic rst;

   dealer_if bus ();

   card_dealer #(.SEED(SEED), .NUM_PAIRS(NUM_PAIRS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- turn-level reference model ----------------
   bit m_matched [16];
   int m_score   [2];
   int m_player;
   bit m_have_first;
   int m_first;
   bit m_done;

   function automatic int mval(input int i);
      return (int'(i % 8) + int'(SEED)) % 8;
   endfunction

   task automatic model_clear();
      foreach (m_matched[i]) m_matched[i] = 1'b0;
      m_score[0]   = 0;
      m_score[1]   = 0;
      m_player     = 0;
      m_have_first = 1'b0;
      m_first      = 0;
      m_done       = 1'b0;
   endtask

   typedef struct {
      bit         timeout;
      logic       valid;
      logic [2:0] card;
      logic       err;
      logic       match;
      logic       mismatch;
      logic       excl;
      logic [3:0] s0;
      logic [3:0] s1;
      logic       player;
      logic       done;
      logic       ready;
   } obs_t;

   function automatic logic one_hot0();
      return ($countones({bus.card_valid, bus.match, bus.mismatch, bus.error}) <= 1);
   endfunction

   // Wait (bounded) for ready, issue a one-cycle pick, capture the response.
   // With judge set, also capture the verdict cycle and the cycle after it.
   task automatic do_pick(input int s, input bit judge, output obs_t o);
      int n;
      n = 0;
      o = '{default: '0};
      while (bus.ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", int'(bus.ready === 1'b1), 1);
      if (bus.ready !== 1'b1) begin
         o.timeout = 1'b1;
         return;
      end
      bus.pick = 1'b1;
      bus.sel  = 4'(s);
      @(negedge clk);
      bus.pick   = 1'b0;
      o.valid    = bus.card_valid;
      o.card     = bus.card;
      o.err      = bus.error;
      o.match    = bus.match;
      o.mismatch = bus.mismatch;
      o.excl     = one_hot0();
      if (judge) begin
         @(negedge clk);
         o.match    = bus.match;
         o.mismatch = bus.mismatch;
         o.excl     = o.excl & one_hot0();
      end
      o.s0     = bus.score0;
      o.s1     = bus.score1;
      o.player = bus.player;
      if (judge) @(negedge clk);
      o.done  = bus.done;
      o.ready = bus.ready;
   endtask

   task automatic pick_model(input int s);
      obs_t o;
      bit   legal;
      bit   judge;
      bit   is_match;
      legal    = !m_matched[s] && !(m_have_first && s == m_first);
      judge    = legal && m_have_first;
      is_match = 1'b0;
      do_pick(s, judge, o);
      if (o.timeout) return;
      if (legal) begin
         if (!m_have_first) begin
            m_have_first = 1'b1;
            m_first      = s;
         end else begin
            is_match     = (mval(m_first) == mval(s));
            m_have_first = 1'b0;
            if (is_match) begin
               m_matched[m_first] = 1'b1;
               m_matched[s]       = 1'b1;
               m_score[m_player]++;
            end else begin
               m_player = 1 - m_player;
            end
            m_done = (m_score[0] + m_score[1] == int'(NUM_PAIRS));
         end
      end
      chk("m_valid",    o.valid, int'(legal));
      chk("m_card",     o.card, legal ? mval(s) : 0);
      chk("m_error",    o.err, int'(!legal));
      chk("m_match",    o.match, int'(judge && is_match));
      chk("m_mismatch", o.mismatch, int'(judge && !is_match));
      chk("m_score0",   o.s0, m_score[0]);
      chk("m_score1",   o.s1, m_score[1]);
      chk("m_player",   o.player, m_player);
      chk("m_done",     o.done, int'(m_done));
      chk("m_ready",    o.ready, !legal ? 1 : (judge ? int'(!m_done) : 0));
      chk("m_excl",     o.excl, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      bus.pick = 1'b0;
      #1;
      chk("rst_ready",  bus.ready, 0);
      chk("rst_done",   bus.done, 0);
      chk("rst_pulses", int'({bus.card_valid, bus.match, bus.mismatch, bus.error}), 0);
      chk("rst_card",   bus.card, 0);
      chk("rst_state",  int'({bus.score0, bus.score1, bus.player}), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_ready0", bus.ready, 0);
      @(negedge clk);
      chk("rel_ready1", bus.ready, 1);
      model_clear();
   endtask

   // ---------------- fixed vectors (SEED=3) ----------------
   typedef struct {
      bit rst_before;
      int sel;
      bit judge;
      bit valid;
      int card;
      bit err;
      bit match;
      bit mismatch;
      int s0;
      int s1;
      int player;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      int   exp_cv    [5];
      int   exp_match [5];
      int   exp_ready [5];

      rst      = 1'b0;
      bus.pick = 1'b0;
      bus.sel  = '0;
      model_clear();

      //            rst sel jdg val card err m  mm s0 s1 pl
      tbl[0]  = '{0,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0,  8, 1, 1, 3, 0, 1, 0, 1, 0, 0};
      tbl[2]  = '{0,  8, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      tbl[3]  = '{0,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      tbl[4]  = '{0,  1, 0, 1, 4, 0, 0, 0, 1, 0, 0};
      tbl[5]  = '{0,  1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      tbl[6]  = '{0,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      tbl[7]  = '{0,  2, 1, 1, 5, 0, 0, 1, 1, 0, 1};
      tbl[8]  = '{0,  5, 0, 1, 0, 0, 0, 0, 1, 0, 1};
      tbl[9]  = '{0,  5, 0, 0, 0, 1, 0, 0, 1, 0, 1};
      tbl[10] = '{0, 13, 1, 1, 0, 0, 1, 0, 1, 1, 1};
      tbl[11] = '{0,  6, 0, 1, 1, 0, 0, 0, 1, 1, 1};
      tbl[12] = '{0,  7, 1, 1, 2, 0, 0, 1, 1, 1, 0};
      tbl[13] = '{1,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{0,  1, 1, 1, 4, 0, 0, 1, 0, 0, 1};

      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst_before) do_reset();
         do_pick(tbl[i].sel, tbl[i].judge, o);
         if (o.timeout) continue;
         chk($sformatf("v%0d_valid", i),    o.valid,    int'(tbl[i].valid));
         chk($sformatf("v%0d_card", i),     o.card,     tbl[i].card);
         chk($sformatf("v%0d_error", i),    o.err,      int'(tbl[i].err));
         chk($sformatf("v%0d_match", i),    o.match,    int'(tbl[i].match));
         chk($sformatf("v%0d_mismatch", i), o.mismatch, int'(tbl[i].mismatch));
         chk($sformatf("v%0d_score0", i),   o.s0,       tbl[i].s0);
         chk($sformatf("v%0d_score1", i),   o.s1,       tbl[i].s1);
         chk($sformatf("v%0d_player", i),   o.player,   tbl[i].player);
         chk($sformatf("v%0d_ready", i),    o.ready,    int'(tbl[i].err || tbl[i].judge));
      end

      // pick held high through the show/judge states
      do_reset();
      exp_cv    = '{1, 0, 1, 0, 0};
      exp_match = '{0, 0, 0, 1, 0};
      exp_ready = '{0, 1, 0, 0, 1};
      bus.pick = 1'b1;
      bus.sel  = 4'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) bus.sel = 4'd11;
         chk($sformatf("hold%0d_cv", k),    bus.card_valid, exp_cv[k]);
         chk($sformatf("hold%0d_match", k), bus.match,      exp_match[k]);
         chk($sformatf("hold%0d_ready", k), bus.ready,      exp_ready[k]);
         chk($sformatf("hold%0d_err", k),   bus.error,      0);
         if (exp_cv[k] == 1) chk($sformatf("hold%0d_card", k), bus.card, 6);
      end
      bus.pick = 1'b0;

      // reset while the second card is on show
      do_reset();
      pick_model(0);
      while (bus.ready !== 1'b1) @(negedge clk);
      bus.pick = 1'b1;
      bus.sel  = 4'd8;
      @(negedge clk);
      bus.pick = 1'b0;
      chk("mid_cv",   bus.card_valid, 1);
      chk("mid_card", bus.card, 3);
      rst = 1'b0;
      #1;
      chk("mid_rst_pulses", int'({bus.card_valid, bus.match, bus.mismatch}), 0);
      @(posedge clk);
      #1;
      chk("mid_no_verdict", int'({bus.match, bus.mismatch}), 0);
      chk("mid_scores",     int'({bus.score0, bus.score1, bus.player}), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rel_ready0", bus.ready, 0);
      @(negedge clk);
      chk("mid_rel_ready1", bus.ready, 1);
      model_clear();
      pick_model(0);
      pick_model(8);

      // player 0 clears the whole board
      do_reset();
      for (int p = 0; p < 8; p++) begin
         pick_model(p);
         pick_model(p + 8);
      end
      chk("all_done",   bus.done, 1);
      chk("all_score0", bus.score0, 8);
      for (int k = 0; k < 6; k++) begin
         bus.pick = 1'b1;
         bus.sel  = 4'(k * 3);
         @(negedge clk);
         chk($sformatf("dn%0d_strobes", k), int'({bus.card_valid, bus.error, bus.match, bus.mismatch}), 0);
         chk($sformatf("dn%0d_ready", k),   bus.ready, 0);
         chk($sformatf("dn%0d_done", k),    bus.done, 1);
      end
      bus.pick = 1'b0;

      // random game against the model
      do_reset();
      for (int it = 0; it < 300; it++) begin
         int s;
         if (m_done) break;
         if (m_have_first && $urandom_range(0, 1) == 1) s = m_first ^ 8;
         else s = int'($urandom_range(0, 15));
         pick_model(s);
      end
      if (m_done) begin
         bus.pick = 1'b1;
         bus.sel  = 4'($urandom_range(0, 15));
         @(negedge clk);
         bus.pick = 1'b0;
         chk("rnd_done_quiet", int'({bus.card_valid, bus.error, bus.match, bus.mismatch}), 0);
         chk("rnd_done_sum", int'(bus.score0) + int'(bus.score1), int'(NUM_PAIRS));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter SEED, default 3, card-value offset applied to the board at reset.
REQ-002 SHALL have parameter NUM_PAIRS, default 8, pairs on the board (16 slots).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pick  input  1  one-cycle request to reveal slot sel.
REQ-006 SHALL have port sel  input  4  slot index 0..15.
REQ-007 SHALL have port ready  output  1  high when a pick is accepted this cycle.
REQ-008 SHALL have port card  output  3  revealed card value, valid when card_valid is high.
REQ-009 SHALL have port card_valid  output  1  one-cycle strobe per revealed card.
REQ-010 SHALL have port player  output  1  current player, 0 or 1.
REQ-011 SHALL have port match  output  1  one-cycle pulse: pair found.
REQ-012 SHALL have port mismatch  output  1  one-cycle pulse: pair not found.
REQ-013 SHALL have port error  output  1  one-cycle pulse: illegal pick rejected.
REQ-014 SHALL have ports score0, score1  output  4  pairs won per player, 0..8.
REQ-015 SHALL have port done  output  1  sticky; all pairs matched.

Function
REQ-016 Board SHALL hold slot i value ((i mod 8) + SEED) mod 8, so slots i and i+8 form a pair; each slot has a matched flag.
REQ-017 FSM states SHALL be WAIT_FIRST, SHOW_FIRST, WAIT_SECOND, SHOW_SECOND, JUDGE, DONE.
REQ-018 ready SHALL be high only in WAIT_FIRST and WAIT_SECOND; pick outside those states SHALL be ignored silently.
REQ-019 Legal pick in WAIT_FIRST (slot unmatched) SHALL latch sel as first slot and go to SHOW_FIRST.
REQ-020 SHOW_FIRST SHALL assert card_valid with the first slot's value for one cycle, then go to WAIT_SECOND.
REQ-021 Legal pick in WAIT_SECOND (slot unmatched and sel != first slot) SHALL latch second slot and go to SHOW_SECOND.
REQ-022 SHOW_SECOND SHALL assert card_valid with the second slot's value for one cycle, then go to JUDGE.
REQ-023 JUDGE SHALL compare the two card values for one cycle; equal: pulse match, set both matched flags, increment current player's score, player unchanged.
REQ-024 JUDGE unequal: pulse mismatch, toggle player, flags and scores unchanged.
REQ-025 JUDGE SHALL go to DONE when the match completes NUM_PAIRS pairs, else to WAIT_FIRST.
REQ-026 Illegal pick (matched slot, or second sel equal to first) SHALL pulse error the next cycle and leave state, scores and player unchanged.
REQ-027 Latency: pick to card_valid SHALL be exactly 1 cycle; second card_valid to match/mismatch exactly 1 cycle.
REQ-028 match, mismatch, error, card_valid SHALL be mutually exclusive in any cycle.
REQ-029 DONE SHALL hold done=1, ready=0 and ignore all picks until reset.
REQ-030 card SHALL read 0 whenever card_valid is low.
REQ-031 score0 + score1 SHALL never exceed NUM_PAIRS; no wrap-around.

Reset
REQ-032 rst low SHALL immediately force WAIT_FIRST, player=0, scores=0, all matched flags clear, board reloaded per REQ-016.
REQ-033 During reset all pulse outputs, card, done SHALL be 0; ready SHALL be 0 while rst is low.
REQ-034 Reset asserted mid-turn SHALL discard the latched first/second slots with no match/mismatch pulse.

Structure
REQ-035 Shared package dealer_pkg SHALL hold the state enum, CARD_W=3, SLOT_W=4, NUM_SLOTS=16.
REQ-036 Board values and matched flags SHALL live in sub-module dealer_board (read port by index, set-matched port for two slots).

Verification
REQ-037 SEED=3: pick 0 then 8 -> card 3, card 3, match; score0=1, player stays 0.
REQ-038 Pick 0 then 1 -> card 3, card 4, mismatch; player becomes 1, scores unchanged.
REQ-039 After 0/8 matched, pick 8 -> error next cycle, ready stays high, state WAIT_FIRST; pick 5 then 5 -> card 0, then error on second.
REQ-040 Match all 8 pairs as player 0 -> score0=8, done=1 after last JUDGE, later picks produce no strobes.
REQ-041 rst low during SHOW_SECOND -> no match/mismatch pulse, scores 0, player 0, ready high one cycle after rst release.
REQ-042 pick held high through SHOW_FIRST/JUDGE -> only the WAIT-state cycles accepted, one card_valid per accepted pick.
